// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM state encoding,
// default geometry, and buffer-occupancy helper.
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [15:0] RESET_PC_DEF = 16'd10;

    // Two-entry instruction buffer between the cache and decode.
    localparam logic [1:0]  BUF_DEPTH    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    // A new request may only be issued when the buffer will have a free slot,
    // so a returning word can always be pushed without back-pressure.
    function automatic logic has_room(input logic [1:0] count_next);
        return count_next < BUF_DEPTH;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {instruction, pc} pairs between the fetch FSM and
// decode. Synchronous flush (branch redirect) takes priority over push/pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int W = DATA_W_DEF + ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Guard against pops when empty and pushes when full without a pop.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != BUF_DEPTH) || do_pop);
    end

    // Storage, pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the two storage words are reset so the head reads as zero
            // after reset; with only two entries this costs nothing meaningful.
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues one word request at a time
// to the L1 cache read port, tags each returned word with its PC and queues it
// for decode. Branch/jump redirects flush the queue and restart fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_req,
    input  logic [DATA_W-1:0] read_data,
    input  logic              data_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              push;
    logic              pop;
    logic              flush;
    logic [1:0]        count;
    logic [1:0]        count_next;

    // Next-state, PC update and buffer control; redirect overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = clk_en && instr_valid && instr_ready;
        count_next = count - 2'(pop);
        if (clk_en) begin
            if (redirect_valid) begin
                // Any in-flight response and same-cycle pop are discarded.
                pc_d    = redirect_pc;
                state_d = ST_ISSUE;
                flush   = (state_q != ST_IDLE);
            end else begin
                unique case (state_q)
                    ST_IDLE:  state_d = ST_ISSUE;
                    ST_ISSUE: state_d = ST_WAIT;
                    ST_WAIT: begin
                        if (data_ready) begin
                            push       = 1'b1;
                            count_next = count_next + 2'd1;
                            pc_d       = pc_q + ADDR_W'(1);
                            state_d    = has_room(count_next) ? ST_ISSUE : ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (has_room(count_next)) state_d = ST_ISSUE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // State and PC registers; clk_en=0 leaves them untouched via the comb defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The PC register doubles as the registered cache address.
    assign read_addr = pc_q;
    assign read_req  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    fetch_buf #(
        .W(DATA_W + ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({read_data, pc_q}),
        .count     (count),
        .head      ({instr, instr_pc})
    );

    assign instr_valid = (count != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase checked against an instruction-stream reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [15:0] read_addr;
    logic        read_req;
    logic [31:0] read_data;
    logic        data_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .read_addr      (read_addr),
        .read_req       (read_req),
        .read_data      (read_data),
        .data_ready     (data_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache contents: two fixed words, everything else derived from the address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'd10:  return 32'h3c0207c3;
            16'd11:  return 32'h3c0307df;
            default: return {a ^ 16'hA5C3, a};
        endcase
    endfunction

    assign read_data = mem_word(read_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst            = 1'b0;
        clk_en         = 1'b0;
        data_ready     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        #1;
        rst = 1'b1;
    endtask

    // Fill the buffer from reset with decode stalled: ends in HOLD with pc 10,11 queued.
    task automatic fill_from_reset();
        pulse_reset();
        clk_en      = 1'b1;
        data_ready  = 1'b1;
        instr_ready = 1'b0;
        repeat (5) tick();
    endtask

    // Stream model: pops must follow consecutive PCs from the last redirect.
    logic [15:0] exp_pc;
    int          pops;
    logic        after_redir;

    initial begin
        rst            = 1'b1;
        clk_en         = 1'b0;
        data_ready     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        #2;
        rst = 1'b0;
        #1;
        chk("reset_read_addr", 64'(read_addr), 64'd10);
        chk("reset_read_req", 64'(read_req), 64'd0);
        chk("reset_valid", 64'(instr_valid), 64'd0);
        chk("reset_instr", 64'(instr), 64'd0);
        chk("reset_instr_pc", 64'(instr_pc), 64'd0);
        rst = 1'b1;

        // 1: free-flowing fetch from the reset PC.
        clk_en      = 1'b1;
        data_ready  = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("t1_e1_req", 64'(read_req), 64'd1);
        chk("t1_e1_addr", 64'(read_addr), 64'd10);
        tick();
        chk("t1_e2_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("t1_e3_valid", 64'(instr_valid), 64'd1);
        chk("t1_e3_instr", 64'(instr), 64'h3c0207c3);
        chk("t1_e3_pc", 64'(instr_pc), 64'd10);
        chk("t1_e3_addr", 64'(read_addr), 64'd11);
        tick();
        chk("t1_e4_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("t1_e5_instr", 64'(instr), 64'h3c0307df);
        chk("t1_e5_pc", 64'(instr_pc), 64'd11);
        chk("t1_e5_addr", 64'(read_addr), 64'd12);

        // 2: decode stalled -> buffer fills, fetch holds, then drains in order.
        fill_from_reset();
        chk("t2_hold_req", 64'(read_req), 64'd0);
        chk("t2_hold_addr", 64'(read_addr), 64'd12);
        chk("t2_hold_pc", 64'(instr_pc), 64'd10);
        tick();
        chk("t2_hold2_req", 64'(read_req), 64'd0);
        chk("t2_hold2_pc", 64'(instr_pc), 64'd10);
        instr_ready = 1'b1;
        tick();
        chk("t2_pop1_pc", 64'(instr_pc), 64'd11);
        chk("t2_pop1_req", 64'(read_req), 64'd1);
        chk("t2_pop1_addr", 64'(read_addr), 64'd12);
        tick();
        chk("t2_pop2_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("t2_resume_pc", 64'(instr_pc), 64'd12);
        chk("t2_resume_instr", 64'(instr), 64'(mem_word(16'd12)));

        // 3: cache stalls for three WAIT cycles.
        pulse_reset();
        clk_en      = 1'b1;
        instr_ready = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_req", 64'(read_req), 64'd1);
            chk("t3_stall_addr", 64'(read_addr), 64'd10);
            chk("t3_stall_valid", 64'(instr_valid), 64'd0);
        end
        data_ready = 1'b1;
        tick();
        chk("t3_push_valid", 64'(instr_valid), 64'd1);
        chk("t3_push_pc", 64'(instr_pc), 64'd10);

        // 4: redirect with full buffer and data_ready, then redirect during WAIT.
        fill_from_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        tick();
        chk("t4_flush_valid", 64'(instr_valid), 64'd0);
        chk("t4_flush_addr", 64'(read_addr), 64'h20);
        chk("t4_flush_req", 64'(read_req), 64'd1);
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("t4_new_pc", 64'(instr_pc), 64'h20);
        chk("t4_new_instr", 64'(instr), 64'(mem_word(16'h20)));
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        chk("t4_drop_valid", 64'(instr_valid), 64'd0);
        chk("t4_drop_addr", 64'(read_addr), 64'h40);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick();
        chk("t4_drop_still_empty", 64'(instr_valid), 64'd0);
        tick();
        chk("t4_after_drop_pc", 64'(instr_pc), 64'h40);

        // 5: PC wraps modulo 2^16.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 16'hFFFF;
        pops   = 0;
        for (int i = 0; i < 30 && pops < 3; i++) begin
            if (instr_valid && instr_ready) begin
                chk("t5_wrap_pc", 64'(instr_pc), 64'(exp_pc));
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            tick();
        end
        chk("t5_wrap_count", 64'(pops), 64'd3);

        // 6: asynchronous reset in WAIT with an entry queued.
        pulse_reset();
        clk_en      = 1'b1;
        data_ready  = 1'b1;
        repeat (4) tick();
        chk("t6_pre_valid", 64'(instr_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_req", 64'(read_req), 64'd0);
        chk("t6_rst_addr", 64'(read_addr), 64'd10);
        chk("t6_rst_valid", 64'(instr_valid), 64'd0);
        chk("t6_rst_instr", 64'(instr), 64'd0);
        chk("t6_rst_pc", 64'(instr_pc), 64'd0);
        rst = 1'b1;
        // Redirect straight out of IDLE loads the PC.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        tick();
        chk("t6_idle_redir_addr", 64'(read_addr), 64'h100);
        chk("t6_idle_redir_req", 64'(read_req), 64'd1);
        redirect_valid = 1'b0;

        // clk_en=0 with a full buffer freezes everything, even redirect and pop.
        fill_from_reset();
        clk_en         = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0055;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_frz_valid", 64'(instr_valid), 64'd1);
            chk("t6_frz_pc", 64'(instr_pc), 64'd10);
            chk("t6_frz_addr", 64'(read_addr), 64'd12);
            chk("t6_frz_req", 64'(read_req), 64'd0);
        end
        redirect_valid = 1'b0;
        clk_en         = 1'b1;
        tick();
        chk("t6_thaw_pc", 64'(instr_pc), 64'd11);

        // Randomized phase against the stream model.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        tick();
        redirect_valid = 1'b0;
        exp_pc      = 16'h0300;
        pops        = 0;
        after_redir = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            clk_en         = ($urandom_range(0, 9) != 0);
            data_ready     = ($urandom_range(0, 9) < 6);
            instr_ready    = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            #1;
            if (clk_en && redirect_valid) begin
                exp_pc      = redirect_pc;
                after_redir = 1'b1;
            end else if (clk_en && instr_valid && instr_ready) begin
                chk("rand_pc", 64'(instr_pc), 64'(exp_pc));
                chk("rand_instr", 64'(instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            tick();
            if (after_redir) begin
                chk("rand_flush", 64'(instr_valid), 64'd0);
                after_redir = 1'b0;
            end
        end
        checks++;
        assert (pops >= 50) else begin
            errors++;
            $error("FAIL rand_progress observed=%0d expected>=%0d", pops, 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
